// File: rtl/mem_pkg.sv
// mem_pkg: shared load/store encodings, FSM states and lane helpers for data_ram and the LSU
package mem_pkg;
  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;
  typedef enum logic {INIT, RUN} state_e;
  typedef struct packed {
    logic       valid;
    logic       error;
    logic       write;
    logic [1:0] size;
    logic       uns;
    logic [1:0] off;
  } stage_t;
  function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] off);
    return size == SIZE_B ? 4'b0001 << off :
           size == SIZE_H ? (off[1] ? 4'b1100 : 4'b0011) :
           size == SIZE_W ? 4'b1111 : 4'b0000;
  endfunction
  function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] size,
                                              input logic [1:0] off, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[8*off +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    return size == SIZE_B ? {{24{b[7] & ~uns}}, b} :
           size == SIZE_H ? {{16{h[15] & ~uns}}, h} : word;
  endfunction
endpackage

// File: rtl/mem_array.sv
// mem_array: single-port 32-bit word array with byte write enables and registered read-first data
module mem_array #(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic [AW-1:0] addr_i,
  input  logic [3:0]    we_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);
  logic [31:0] mem_q [2**AW];
  logic [31:0] rdata_q;
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) if (we_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
    rdata_q <= mem_q[addr_i];
  end
  assign rdata_o = rdata_q;
endmodule

// File: rtl/data_ram.sv
// data_ram: byte-addressable load/store memory with post-reset clear and fixed-latency responses
module data_ram
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH   = 10,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH+1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_error
);
  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  stage_t                s1_q, s1_d;
  logic                  acc, err, v1, e1;
  logic [3:0]            we;
  logic [31:0]           wdata, rdata, d1;
  logic [ADDR_WIDTH-1:0] addr;
  always_comb begin
    req_ready = state_q == RUN && !rst;
    acc       = req_valid && req_ready;
    err       = req_size == 2'b11 || (req_size == SIZE_H && req_addr[0]) ||
                (req_size == SIZE_W && req_addr[1:0] != 2'b00);
    state_d   = state_q == INIT && &cnt_q ? RUN : state_q;
    cnt_d     = state_q == INIT ? cnt_q + 1'b1 : cnt_q;
    addr      = state_q == INIT ? cnt_q : req_addr[ADDR_WIDTH+1:2];
    we        = state_q == INIT ? 4'hf :
                acc && req_write && !err ? byte_enables(req_size, req_addr[1:0]) : 4'h0;
    // narrow stores are replicated across lanes so the enables alone pick the target bytes
    wdata     = state_q == INIT ? '0 :
                req_size == SIZE_B ? {4{req_wdata[7:0]}} :
                req_size == SIZE_H ? {2{req_wdata[15:0]}} : req_wdata;
    s1_d      = '{valid: acc, error: err, write: req_write, size: req_size,
                  uns: req_unsigned, off: req_addr[1:0]};
    v1        = s1_q.valid;
    e1        = s1_q.valid && s1_q.error;
    d1        = s1_q.valid && !s1_q.error && !s1_q.write ?
                load_extend(rdata, s1_q.size, s1_q.off, s1_q.uns) : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT;
      cnt_q   <= '0;
      s1_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      s1_q    <= s1_d;
    end
  end
  mem_array #(.AW(ADDR_WIDTH)) u_array (
    .clk     (clk),
    .addr_i  (addr),
    .we_i    (we),
    .wdata_i (wdata),
    .rdata_o (rdata)
  );
  if (READ_LATENCY == 1) begin : g_lat1
    assign {rsp_valid, rsp_error, rsp_rdata} = {v1, e1, d1};
  end else if (READ_LATENCY == 2) begin : g_lat2
    logic [33:0] out_q;
    always_ff @(posedge clk) begin
      if (rst) out_q <= '0;
      else out_q <= {v1, e1, d1};
    end
    assign {rsp_valid, rsp_error, rsp_rdata} = out_q;
  end else begin : g_bad_latency
    $error("data_ram: READ_LATENCY must be 1 or 2");
  end
endmodule

// File: tb/tb_data_ram.sv
// tb_data_ram: byte-level memory model checks two data_ram instances (latency 1 and 2) every cycle
module tb_data_ram;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_write = 1'b0, req_unsigned = 1'b0;
  logic [1:0]  req_size = 2'b10;
  logic [5:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rdy1, rdy2, v1, v2, e1, e2;
  logic [31:0] d1, d2;
  int          total = 0, bad = 0;
  logic [7:0]  mb [64];
  int          init_cnt = 0;
  logic [33:0] exp1 = '0, exp2 = '0;
  bit          started = 0;

  always #5 clk = ~clk;

  data_ram #(.ADDR_WIDTH(4), .READ_LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy1), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(v1), .rsp_rdata(d1), .rsp_error(e1));
  data_ram #(.ADDR_WIDTH(4), .READ_LATENCY(2)) dut2 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(rdy2), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(v2), .rsp_rdata(d2), .rsp_error(e2));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, want);
    end
  endtask

  // returns {error, rdata}; applies stores byte by byte to the model
  function automatic logic [32:0] model_rsp(input logic w, input logic [1:0] sz, input logic uns,
                                            input logic [5:0] a, input logic [31:0] wd);
    int          n;
    logic [31:0] v;
    n = 1 << sz;
    if (sz == 2'b11 || a % n != 0) return {1'b1, 32'h0};
    if (w) begin
      for (int k = 0; k < n; k++) mb[a + k] = wd[8*k +: 8];
      return '0;
    end
    v = '0;
    for (int k = 0; k < n; k++) v[8*k +: 8] = mb[a + k];
    if (n < 4 && !uns && v[8*n-1]) v = v | ~((32'h1 << (8*n)) - 1);
    return {1'b0, v};
  endfunction

  initial begin
    logic       c_rst, c_v, c_w, c_u, acc;
    logic [1:0] c_sz;
    logic [5:0] c_a;
    logic [31:0] c_wd;
    forever begin
      @(posedge clk);
      {c_rst, c_v, c_w, c_u, c_sz, c_a, c_wd} = {rst, req_valid, req_write, req_unsigned, req_size, req_addr, req_wdata};
      #1;
      if (c_rst) begin
        started = 1;
        init_cnt = 0;
        exp1 = '0;
        exp2 = '0;
        for (int i = 0; i < 64; i++) mb[i] = 8'h00;
      end else begin
        acc = c_v && init_cnt == 16;
        exp2 = exp1;
        exp1 = acc ? {1'b1, model_rsp(c_w, c_sz, c_u, c_a, c_wd)} : 34'h0;
        if (init_cnt < 16) init_cnt++;
      end
      if (started) begin
        chk("rsp_lat1", {v1, e1, d1}, exp1);
        chk("rsp_lat2", {v2, e2, d2}, exp2);
        chk("ready", {rdy1, rdy2}, {2{!rst && init_cnt == 16}});
      end
    end
  end

  task automatic op(input string nm, input logic w, input logic [1:0] sz, input logic uns,
                    input logic [5:0] a, input logic [31:0] wd, input logic xe, input logic [31:0] xd);
    @(negedge clk);
    {req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata} = {1'b1, w, sz, uns, a, wd};
    @(negedge clk);
    req_valid = 1'b0;
    chk(nm, {v1, e1, d1}, {1'b1, xe, xd});
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_outputs", {rdy1, v1, e1, d1, v2, e2, d2}, '0);
    for (int i = 1; i < 16; i++) begin
      @(negedge clk);
      chk("init_ready_low", {rdy1, rdy2}, 2'b00);
    end
    @(negedge clk);
    chk("init_ready_high", {rdy1, rdy2}, 2'b11);
    for (int i = 0; i < 16; i++) op("lw_cleared", 0, 2'b10, 0, 6'(i * 4), 0, 0, 32'h0);
    op("sw_deadbeef", 1, 2'b10, 0, 6'h08, 32'hDEADBEEF, 0, 32'h0);
    op("lb_09",  0, 2'b00, 0, 6'h09, 0, 0, 32'hFFFFFFBE);
    op("lbu_0b", 0, 2'b00, 1, 6'h0B, 0, 0, 32'h000000DE);
    op("lh_0a",  0, 2'b01, 0, 6'h0A, 0, 0, 32'hFFFFDEAD);
    op("lhu_0a", 0, 2'b01, 1, 6'h0A, 0, 0, 32'h0000DEAD);
    op("sb_09",  1, 2'b00, 0, 6'h09, 32'hAAAAAA55, 0, 32'h0);
    op("lw_08",  0, 2'b10, 0, 6'h08, 0, 0, 32'hDEAD55EF);
    op("lh_08_pos", 0, 2'b01, 0, 6'h08, 0, 0, 32'h000055EF);
    op("lb_08_neg", 0, 2'b00, 0, 6'h08, 0, 0, 32'hFFFFFFEF);
    op("lw_mis_06", 0, 2'b10, 0, 6'h06, 0, 1, 32'h0);
    op("sh_mis_03", 1, 2'b01, 0, 6'h03, 32'h0000BEEF, 1, 32'h0);
    op("size11",    1, 2'b11, 0, 6'h08, 32'h11111111, 1, 32'h0);
    op("lw_08_kept", 0, 2'b10, 0, 6'h08, 0, 0, 32'hDEAD55EF);
    op("sh_top",  1, 2'b01, 0, 6'h3E, 32'h00008001, 0, 32'h0);
    op("lw_top",  0, 2'b10, 0, 6'h3C, 0, 0, 32'h80010000);
    @(negedge clk);
    {req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata} = {1'b1, 1'b1, 2'b10, 1'b0, 6'h10, 32'h12345678};
    @(negedge clk);
    {req_write, req_wdata} = {1'b0, 32'h0};
    chk("b2b_store_l1", {v1, e1, d1}, {1'b1, 1'b0, 32'h0});
    chk("b2b_idle_l2", {v2, e2, d2}, '0);
    @(negedge clk);
    req_valid = 1'b0;
    chk("b2b_load_l1", {v1, e1, d1}, {1'b1, 1'b0, 32'h12345678});
    chk("b2b_store_l2", {v2, e2, d2}, {1'b1, 1'b0, 32'h0});
    @(negedge clk);
    chk("b2b_load_l2", {v2, e2, d2}, {1'b1, 1'b0, 32'h12345678});
    chk("b2b_done_l1", {v1, e1, d1}, '0);
    @(negedge clk);
    {req_valid, req_write, req_size, req_addr} = {1'b1, 1'b0, 2'b10, 6'h10};
    @(negedge clk);
    req_addr = 6'h08;
    rst = 1'b1;
    @(negedge clk);
    {rst, req_valid} = 2'b00;
    chk("flush_l1", {v1, e1, d1}, '0);
    chk("flush_l2", {v2, e2, d2}, '0);
    @(negedge clk);
    chk("flush_l2_later", {v2, e2, d2}, '0);
    repeat (15) @(negedge clk);
    chk("reinit_ready", {rdy1, rdy2}, 2'b11);
    op("lw_10_cleared", 0, 2'b10, 0, 6'h10, 0, 0, 32'h0);
    op("lw_08_cleared", 0, 2'b10, 0, 6'h08, 0, 0, 32'h0);
    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
